sram_axi_master: RTL and testbench

Single-outstanding AXI master bridge: it accepts SRAM-like requests from the CPU/fetch side and issues single-beat AXI read or write transactions. It is the initiator counterpart to the SRAM-side AXI slave bridge. The two can be connected back-to-back, so a core with a simple `req/addr_ok/data_ok` port can reach AXI-attached SRAM. Widths match the AXI definitions in `defines.vh` (32-bit address, 32-bit data, 4-bit ID).

---
 rtl/sram_axi_master.sv | 206 ++++++++++++++++++++
 tb/tb_sram_axi_master.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_master.sv
// sram_axi_master: single-outstanding bridge from an SRAM-like req/addr_ok/data_ok
// port to single-beat AXI read and write transactions.
// Optional feature macro: SRAM_AXI_MASTER_ERR_EN. When it is defined, a non-OKAY
// R or B response sets a sticky err flag. When it is not defined, err is tied low.
module sram_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                aclk,
  input  logic                areset,
  // CPU side
  input  logic                req,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  // AXI read address channel
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ID_W-1:0]     m_arid,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic [1:0]          m_arlock,
  output logic [3:0]          m_arcache,
  output logic [2:0]          m_arprot,
  // AXI read data channel
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  // AXI write address channel
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ID_W-1:0]     m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [1:0]          m_awlock,
  output logic [3:0]          m_awcache,
  output logic [2:0]          m_awprot,
  // AXI write data channel
  output logic [DATA_W-1:0]   m_wdata,
  output logic [ID_W-1:0]     m_wid,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  // AXI write response channel
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_A  = 3'd1;
  localparam logic [2:0] RD_D  = 3'd2;
  localparam logic [2:0] WR_AW = 3'd3;
  localparam logic [2:0] WR_B  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]          state;
  logic [2:0]          next_state;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                aw_done;
  logic                w_done;
  logic                aw_fin;
  logic                w_fin;
  logic [2:0]          ax_size;

  // All handshake outputs decode from registered state, so no AXI input
  // reaches an AXI output combinationally. Only addr_ok looks at req.
  assign addr_ok   = (state == IDLE) && req;
  assign data_ok   = (state == DONE);
  assign rdata     = rdata_q;
  assign m_arvalid = (state == RD_A);
  assign m_rready  = (state == RD_D);
  assign m_awvalid = (state == WR_AW) && !aw_done;
  assign m_wvalid  = (state == WR_AW) && !w_done;
  assign m_bready  = (state == WR_B);

  // A channel counts as finished if it completed earlier or completes now.
  assign aw_fin = aw_done || m_awready;
  assign w_fin  = w_done  || m_wready;

  // Size 3 is not a legal request on this port, so it falls back to a word.
  assign ax_size = (size_q == 2'd3) ? 3'b010 : {1'b0, size_q};

  assign m_araddr  = addr_q;
  assign m_arid    = '0;
  assign m_arlen   = 8'd0;
  assign m_arsize  = ax_size;
  assign m_arburst = 2'b01;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;

  assign m_awaddr  = addr_q;
  assign m_awid    = '0;
  assign m_awlen   = 8'd0;
  assign m_awsize  = ax_size;
  assign m_awburst = 2'b01;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'b0000;
  assign m_awprot  = 3'b000;

  assign m_wdata   = wdata_q;
  assign m_wid     = '0;
  assign m_wstrb   = wstrb_q;
  assign m_wlast   = 1'b1;

  // Next-state logic. The transfer direction lives in the state itself, so
  // the request's wr bit is only needed at the moment of acceptance.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = wr ? WR_AW : RD_A;
      RD_A:    if (m_arready) next_state = RD_D;
      RD_D:    if (m_rvalid) next_state = DONE;
      WR_AW:   if (aw_fin && w_fin) next_state = WR_B;
      WR_B:    if (m_bvalid) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; a reset abandons any transaction in flight.
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  // Capture the request on acceptance so AXI address and data stay stable.
  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (addr_ok) begin
      addr_q  <= addr;
      size_q  <= size;
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // Per-channel done flags let AW and W complete in either order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == WR_AW) begin
      if (m_awvalid && m_awready) aw_done <= 1'b1;
      if (m_wvalid && m_wready)   w_done  <= 1'b1;
    end else begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end
  end

  // Read data is held from the R handshake through the data_ok cycle.
  always_ff @(posedge aclk) begin
    if (areset)                   rdata_q <= '0;
    else if (m_rready && m_rvalid) rdata_q <= m_rdata;
  end

`ifdef SRAM_AXI_MASTER_ERR_EN
  logic err_q;
  logic unused_resp_fields;

  assign err = err_q;
  assign unused_resp_fields = ^{m_rid, m_bid, m_rlast};

  // Sticky error: any non-OKAY R or B response sets it until reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_q <= 1'b0;
    end else if ((m_rready && m_rvalid && (m_rresp != 2'b00)) ||
                 (m_bready && m_bvalid && (m_bresp != 2'b00))) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_resp_fields;

  assign err = 1'b0;
  assign unused_resp_fields = ^{m_rid, m_bid, m_rlast, m_rresp, m_bresp};
`endif

endmodule

// File: tb/tb_sram_axi_master.sv
// tb_sram_axi_master: directed bench for sram_axi_master. A delay-programmable
// slave model answers each AXI channel; expected values are hand-computed.
module tb_sram_axi_master;

`ifdef SRAM_AXI_MASTER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [1:0]  m_arlock;
  logic [3:0]  m_arcache;
  logic [2:0]  m_arprot;
  logic [31:0] m_rdata;
  logic [3:0]  m_rid;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [3:0]  m_awid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic [1:0]  m_awlock;
  logic [3:0]  m_awcache;
  logic [2:0]  m_awprot;
  logic [31:0] m_wdata;
  logic [3:0]  m_wid;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready;
  logic [3:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  int checks = 0;
  int failures = 0;

  // Slave model configuration and per-channel wait counters
  int ar_dly, aw_dly, w_dly, r_dly, b_dly;
  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic [31:0] slave_rdata;
  logic [1:0]  slave_resp;

  // Observations collected during one transaction
  int          obs_latency;
  int          obs_awcyc;
  int          obs_wcyc;
  logic        obs_done;
  logic        obs_overlap;
  logic        obs_aw_stable;
  logic [31:0] obs_rdata;
  logic [31:0] obs_araddr;
  logic [2:0]  obs_arsize;
  logic [7:0]  obs_arlen;
  logic [1:0]  obs_arburst;
  logic [31:0] obs_awaddr;
  logic [2:0]  obs_awsize;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_wstrb;
  logic        obs_wlast;

  logic [11:0] aok_bits;
  logic [11:0] dok_bits;
  logic        b2b_overlap;

  always #5 aclk = ~aclk;

  sram_axi_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .aclk(aclk), .areset(areset),
    .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_wdata(m_wdata), .m_wid(m_wid), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearSlave();
    ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    slave_resp = 2'b00;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_rvalid = 1'b0; m_bvalid = 1'b0;
    m_rresp = 2'b00; m_bresp = 2'b00;
  endtask

  // Slave model: each channel answers after its programmed number of wait cycles
  task automatic slaveDrive();
    if (m_arvalid && ar_cnt >= ar_dly) begin m_arready = 1'b1; ar_cnt = 0; end
    else begin m_arready = 1'b0; if (m_arvalid) ar_cnt++; end
    if (m_awvalid && aw_cnt >= aw_dly) begin m_awready = 1'b1; aw_cnt = 0; end
    else begin m_awready = 1'b0; if (m_awvalid) aw_cnt++; end
    if (m_wvalid && w_cnt >= w_dly) begin m_wready = 1'b1; w_cnt = 0; end
    else begin m_wready = 1'b0; if (m_wvalid) w_cnt++; end
    if (m_rready && r_cnt >= r_dly) begin m_rvalid = 1'b1; r_cnt = 0; end
    else begin m_rvalid = 1'b0; if (m_rready) r_cnt++; end
    if (m_bready && b_cnt >= b_dly) begin m_bvalid = 1'b1; b_cnt = 0; end
    else begin m_bvalid = 1'b0; if (m_bready) b_cnt++; end
    m_rdata = slave_rdata;
    m_rresp = slave_resp;
    m_bresp = slave_resp;
  endtask

  task automatic resetDut();
    @(posedge aclk); #1;
    areset = 1'b1;
    req = 1'b0;
    clearSlave();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  // One request pulse, then run the slave until data_ok (bounded at 40 cycles)
  task automatic applyStimulus(input logic wr_i, input logic [1:0] size_i,
                               input logic [31:0] addr_i, input logic [31:0] wdata_i,
                               input logic [3:0] wstrb_i);
    int cyc;
    logic seen_ar, seen_aw, seen_w;
    @(posedge aclk); #1;
    req = 1'b1; wr = wr_i; size = size_i; addr = addr_i; wdata = wdata_i; wstrb = wstrb_i;
    slaveDrive();
    @(negedge aclk);
    checkOutput("addr_ok_accept", 32'(addr_ok), 32'd1);
    obs_done = 1'b0; obs_overlap = 1'b0; obs_aw_stable = 1'b1;
    obs_awcyc = 0; obs_wcyc = 0; obs_latency = 0;
    seen_ar = 1'b0; seen_aw = 1'b0; seen_w = 1'b0;
    cyc = 0;
    while (!obs_done && cyc < 40) begin
      @(posedge aclk); #1;
      req = 1'b0;
      cyc++;
      slaveDrive();
      @(negedge aclk);
      if (m_arvalid && !seen_ar) begin
        seen_ar = 1'b1;
        obs_araddr = m_araddr; obs_arsize = m_arsize;
        obs_arlen = m_arlen; obs_arburst = m_arburst;
      end
      if (m_awvalid) begin
        obs_awcyc++;
        if (!seen_aw) begin
          seen_aw = 1'b1; obs_awaddr = m_awaddr; obs_awsize = m_awsize;
        end else if (m_awaddr !== obs_awaddr) begin
          obs_aw_stable = 1'b0;
        end
      end
      if (m_wvalid) begin
        obs_wcyc++;
        if (!seen_w) begin
          seen_w = 1'b1; obs_wdata = m_wdata; obs_wstrb = m_wstrb; obs_wlast = m_wlast;
        end
      end
      if (m_arvalid && (m_awvalid || m_wvalid)) obs_overlap = 1'b1;
      if (data_ok) begin
        obs_done = 1'b1;
        obs_latency = cyc;
        obs_rdata = rdata;
      end
    end
    checkOutput("txn_completed", 32'(obs_done), 32'd1);
  endtask

  initial begin
    areset = 1'b1;
    req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'd0; addr = '0; wdata = '0;
    m_rid = 4'd0; m_bid = 4'd0; m_rlast = 1'b1;
    slave_rdata = '0;
    clearSlave();
    m_rdata = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("rst_addr_ok", 32'(addr_ok), 32'd0);
    checkOutput("rst_data_ok", 32'(data_ok), 32'd0);
    checkOutput("rst_arvalid", 32'(m_arvalid), 32'd0);
    checkOutput("rst_awvalid", 32'(m_awvalid), 32'd0);
    checkOutput("rst_wvalid", 32'(m_wvalid), 32'd0);
    checkOutput("rst_rready", 32'(m_rready), 32'd0);
    checkOutput("rst_bready", 32'(m_bready), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // Read with a ready slave
    slave_rdata = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 2'd2, 32'h0000_0100, 32'h0, 4'h0);
    checkOutput("rd_latency", 32'(obs_latency), 32'd3);
    checkOutput("rd_rdata", obs_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_arsize", 32'(obs_arsize), 32'd2);
    checkOutput("rd_arlen", 32'(obs_arlen), 32'd0);
    checkOutput("rd_arburst", 32'(obs_arburst), 32'd1);
    checkOutput("rd_araddr", obs_araddr, 32'h0000_0100);
    checkOutput("rd_overlap", 32'(obs_overlap), 32'd0);
    checkOutput("rd_err", 32'(err), 32'd0);

    // Write with AW stalled three cycles, W ready at once
    aw_dly = 3;
    applyStimulus(1'b1, 2'd2, 32'h0000_0020, 32'h1234_5678, 4'b0011);
    checkOutput("wr_aw_latency", 32'(obs_latency), 32'd6);
    checkOutput("wr_aw_wcyc", 32'(obs_wcyc), 32'd1);
    checkOutput("wr_aw_awcyc", 32'(obs_awcyc), 32'd4);
    checkOutput("wr_aw_stable", 32'(obs_aw_stable), 32'd1);
    checkOutput("wr_awaddr", obs_awaddr, 32'h0000_0020);
    checkOutput("wr_awsize", 32'(obs_awsize), 32'd2);
    checkOutput("wr_wdata", obs_wdata, 32'h1234_5678);
    checkOutput("wr_wstrb", 32'(obs_wstrb), 32'b0011);
    checkOutput("wr_wlast", 32'(obs_wlast), 32'd1);
    aw_dly = 0;

    // Write with W stalled two cycles, AW ready at once
    w_dly = 2;
    applyStimulus(1'b1, 2'd1, 32'h0000_0044, 32'hA5A5_0F0F, 4'b1100);
    checkOutput("wr_w_latency", 32'(obs_latency), 32'd5);
    checkOutput("wr_w_awcyc", 32'(obs_awcyc), 32'd1);
    checkOutput("wr_w_wcyc", 32'(obs_wcyc), 32'd3);
    checkOutput("wr_w_awsize", 32'(obs_awsize), 32'd1);
    w_dly = 0;

    // Read with AR stalled one cycle and R delayed two cycles
    ar_dly = 1; r_dly = 2;
    slave_rdata = 32'hCAFE_F00D;
    applyStimulus(1'b0, 2'd2, 32'h0000_0200, 32'h0, 4'h0);
    checkOutput("rd_stall_latency", 32'(obs_latency), 32'd6);
    checkOutput("rd_stall_rdata", obs_rdata, 32'hCAFE_F00D);
    ar_dly = 0; r_dly = 0;

    // Byte read at an odd address
    slave_rdata = 32'h0000_00AB;
    applyStimulus(1'b0, 2'd0, 32'h0000_0003, 32'h0, 4'h0);
    checkOutput("byte_arsize", 32'(obs_arsize), 32'd0);
    checkOutput("byte_araddr", obs_araddr, 32'h0000_0003);

    // Illegal size 3 falls back to a word transfer
    slave_rdata = 32'h5A5A_0001;
    applyStimulus(1'b0, 2'd3, 32'h0000_0008, 32'h0, 4'h0);
    checkOutput("size3_arsize", 32'(obs_arsize), 32'd2);

    // Back-to-back reads with req held high
    aok_bits = '0; dok_bits = '0; b2b_overlap = 1'b0;
    @(posedge aclk); #1;
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0080;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge aclk); #1;
      end
      if (c == 9) req = 1'b0;
      slaveDrive();
      @(negedge aclk);
      aok_bits[c] = addr_ok;
      dok_bits[c] = data_ok;
      if (m_arvalid && m_awvalid) b2b_overlap = 1'b1;
    end
    checkOutput("b2b_addr_ok", 32'(aok_bits), 32'h111);
    checkOutput("b2b_data_ok", 32'(dok_bits), 32'h888);
    checkOutput("b2b_overlap", 32'(b2b_overlap), 32'd0);

    // Reset while waiting in RD_D with rvalid low
    @(posedge aclk); #1;
    r_dly = 10;
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0040;
    slaveDrive();
    @(posedge aclk); #1;
    req = 1'b0;
    slaveDrive();
    @(posedge aclk); #1;
    slaveDrive();
    @(negedge aclk);
    checkOutput("mid_rst_pre_rready", 32'(m_rready), 32'd1);
    areset = 1'b1;
    @(posedge aclk); #1;
    clearSlave();
    @(negedge aclk);
    checkOutput("mid_rst_rready", 32'(m_rready), 32'd0);
    checkOutput("mid_rst_data_ok", 32'(data_ok), 32'd0);
    checkOutput("mid_rst_rdata", rdata, 32'd0);
    checkOutput("mid_rst_arvalid", 32'(m_arvalid), 32'd0);
    areset = 1'b0;
    req = 1'b1;
    #1;
    checkOutput("mid_rst_idle", 32'(addr_ok), 32'd1);
    req = 1'b0;

    // Error response on B, then stickiness across an OKAY read, then reset
    slave_resp = 2'b10; b_dly = 1;
    applyStimulus(1'b1, 2'd2, 32'h0000_0060, 32'h0BAD_0BAD, 4'hF);
    checkOutput("berr_latency", 32'(obs_latency), 32'd4);
    checkOutput("berr_err", 32'(err), 32'(ERR_EXP));
    slave_resp = 2'b00; b_dly = 0;
    slave_rdata = 32'h1111_2222;
    applyStimulus(1'b0, 2'd2, 32'h0000_0064, 32'h0, 4'h0);
    checkOutput("err_sticky", 32'(err), 32'(ERR_EXP));
    resetDut();
    @(negedge aclk);
    checkOutput("err_cleared", 32'(err), 32'd0);

    // Error response on R still delivers the data
    slave_resp = 2'b11;
    slave_rdata = 32'h7777_8888;
    applyStimulus(1'b0, 2'd2, 32'h0000_0068, 32'h0, 4'h0);
    checkOutput("rerr_rdata", obs_rdata, 32'h7777_8888);
    checkOutput("rerr_err", 32'(err), 32'(ERR_EXP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
